mdu_sched_ctrl: RTL and testbench
=================================

// Module: mdu_sched_ctrl
// PURPOSE
//  Shares one multi-cycle multiply/divide unit between NUM_REQ reservation stations and sequences it.
//  - Round-robin arbiter picks one requester.
//  - FSM runs a fixed-latency multiply or a 32-iteration restoring divide (ops per rv32i_types::mdu_op_type).
//  - Result is held on a valid/ready port toward the CDB/ROB.
//  - One operation in flight at a time; flush kills it.
// PARAMETERS
//  NUM_REQ  2  number of requesting reservation stations (>=1)
//  TAG_W    5  ROB tag width carried with each op
//  MUL_LAT  3  cycles from accept edge to res_valid for multiplies (>=1)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              reset; asynchronous, active-high
//  req_valid  in   NUM_REQ        per-requester op valid
//  req_ready  out  NUM_REQ        one-hot grant; transfer on req_valid[i]&req_ready[i]
//  req_op     in   NUM_REQ*3      mdu_op_type per requester, slice i = [3*i+:3]
//  req_a      in   NUM_REQ*32     rs1 operand per requester
//  req_b      in   NUM_REQ*32     rs2 operand per requester
//  req_tag    in   NUM_REQ*TAG_W  ROB tag per requester
//  flush      in   1              synchronous kill of in-flight op (mispredict)
//  res_valid  out  1              result valid
//  res_ready  in   1              consumer accepts result
//  res_data   out  32             result word
//  res_tag    out  TAG_W          ROB tag of result
//  busy       out  1              high whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, res_valid=0, res_data=0, res_tag=0, busy=0; all internal regs cleared.
//  Reset mid-operation aborts the op with no output.
//  States: IDLE, MUL, DIV, FIX, DONE.
//  IDLE (arbitration):
//   - req_ready is combinational, nonzero only in IDLE with flush=0.
//   - Winner = first i with req_valid[i], scanning from rr_ptr upward modulo NUM_REQ.
//   - On transfer: latch op/a/b/tag; rr_ptr <= (winner+1) mod NUM_REQ.
//   - mul* ops go to MUL; div* and rem* ops go to DIV.
//  MUL:
//   - Form the 64-bit product: signed x signed for mul/mulh, signed x unsigned for mulhsu, unsigned x unsigned for mulhu.
//   - mul returns product[31:0]; mulh/mulhsu/mulhu return product[63:32].
//   - Counter counts MUL_LAT edges, then DONE. res_valid is first high MUL_LAT cycles after the accept edge.
//  DIV, first cycle special cases (go straight to DONE; res_valid 1 cycle after accept):
//   - b==0: div/divu -> 0xFFFFFFFF; rem/remu -> a.
//   - div/rem with a=0x80000000, b=0xFFFFFFFF: div -> 0x80000000; rem -> 0.
//  DIV, otherwise:
//   - Signed ops take operand magnitudes.
//   - One restoring shift-subtract iteration per cycle, 32 iterations, then FIX.
//  FIX:
//   - Quotient negated if signed and operand signs differ; remainder takes the dividend's sign.
//   - Then DONE. Normal divide: res_valid first high 33 cycles after the accept edge.
//  DONE:
//   - res_valid=1; res_data and res_tag are stable until res_valid&res_ready, then IDLE.
//   - No accept in the same cycle as result handshake; next accept is the following cycle at the earliest.
//  flush (highest priority, any state):
//   - Next state IDLE, res_valid low the next cycle, result discarded.
//   - rr_ptr is not changed; req_ready=0 during the flush cycle.
//  Simultaneous flush and res handshake: the result counts as consumed; state goes to IDLE.
//  Arithmetic: all 32-bit results wrap, no exceptions. Opcodes of unselected requesters are ignored.
// TESTING
//  T1 mul a=7, b=0xFFFFFFFD -> 0xFFFFFFEB; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//     mulhsu 0xFFFFFFFF x 2 -> 0xFFFFFFFF; res_valid exactly 3 cycles after accept.
//  T2 div a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF;
//     divu 100/7 -> 14; remu -> 2; res_valid exactly 33 cycles after accept.
//  T3 divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000;
//     rem -> 0; each valid 1 cycle after accept.
//  T4 both requesters valid continuously from reset, res_ready=1 -> grants 0,1,0,1;
//     only req 1 valid -> grant 1 every time; res_tag matches the winner's tag.
//  T5 res_ready=0 for 10 cycles in DONE -> res_valid, res_data, res_tag unchanged,
//     req_ready=0, busy=1; release -> IDLE next cycle.
//  T6 flush 10 cycles into DIV -> no res_valid, busy=0 next cycle, next request accepted normally;
//     rst pulse mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_sched_ctrl.sv
// rtl/mdu_sched_ctrl.sv - shared multiply/divide unit sequencer with round-robin arbitration
// One op in flight: arbitrate in IDLE, run MUL or restoring DIV, hold the result until taken.

module mdu_sched_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*3-1:0]   req_op,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic                   flush,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic                   busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = ($clog2(MUL_LAT) > 5) ? $clog2(MUL_LAT) : 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  mdu_op_e            op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        quo_q, quo_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        res_data_q, res_data_d;

  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx_p;
  int                 idx;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [TAG_W-1:0]   sel_tag;

  // Round-robin scan starting at rr_ptr; the winner's fields are muxed out for latching.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    idx_p   = '0;
    grant   = '0;
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_p = PTR_W'(idx);
      if (!found && req_valid[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && win == PTR_W'(i)) begin
        grant[i] = 1'b1;
        sel_op   = req_op[3*i +: 3];
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
        sel_tag  = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE && !flush) ? grant : '0;

  logic        a_sgn, b_sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] mul_res;

  // Sign-extend to 64 bits so one unsigned multiply covers all signedness combinations.
  always_comb begin
    a_sgn   = (op_q != OP_MULHU);
    b_sgn   = (op_q == OP_MUL) || (op_q == OP_MULH);
    mul_a   = {{32{a_sgn & a_q[31]}}, a_q};
    mul_b   = {{32{b_sgn & b_q[31]}}, b_q};
    prod    = mul_a * mul_b;
    mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
  end

  logic        div_sgn, is_rem;
  logic [31:0] mag_a, mag_b;
  logic [31:0] rem_in, quo_in;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] q_fix, r_fix;

  // First DIV cycle seeds the shift register from the dividend magnitude directly.
  always_comb begin
    div_sgn = !op_q[0];
    is_rem  = op_q[1];
    mag_a   = (div_sgn && a_q[31]) ? -a_q : a_q;
    mag_b   = (div_sgn && b_q[31]) ? -b_q : b_q;
    rem_in  = (cnt_q == '0) ? 32'd0 : rem_q;
    quo_in  = (cnt_q == '0) ? mag_a : quo_q;
    shifted = {rem_in, quo_in[31]};
    ge      = shifted >= {1'b0, mag_b};
    rem_nx  = ge ? 32'(shifted - {1'b0, mag_b}) : shifted[31:0];
    quo_nx  = {quo_in[30:0], ge};
    q_fix   = (div_sgn && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
    r_fix   = (div_sgn && a_q[31]) ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_ready) begin
          op_d     = mdu_op_e'(sel_op);
          a_d      = sel_a;
          b_d      = sel_b;
          tag_d    = sel_tag;
          cnt_d    = '0;
          rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_d  = sel_op[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          res_data_d = mul_res;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (cnt_q == '0 && b_q == 32'd0) begin
          res_data_d = is_rem ? a_q : 32'hFFFF_FFFF;
          state_d    = ST_DONE;
        end else if (cnt_q == '0 && div_sgn && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          res_data_d = is_rem ? 32'd0 : 32'h8000_0000;
          state_d    = ST_DONE;
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
          if (cnt_q == CNT_W'(31)) state_d = ST_FIX;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_FIX: begin
        res_data_d = is_rem ? r_fix : q_fix;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      res_data_q <= res_data_d;
    end
  end

  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_data_q;
  assign res_tag   = tag_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdu_sched_ctrl.sv
// tb/tb_mdu_sched_ctrl.sv - directed self-checking bench for mdu_sched_ctrl
// Each task drives one scenario and compares against hand-computed values.

module tb_mdu_sched_ctrl;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*3-1:0]     req_op;
  logic [NUM_REQ*32-1:0]    req_a;
  logic [NUM_REQ*32-1:0]    req_b;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                     flush;
  logic                     res_valid;
  logic                     res_ready;
  logic [31:0]              res_data;
  logic [TAG_W-1:0]         res_tag;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  mdu_sched_ctrl #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MUL_LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; flush = 1'b0; res_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_req(input int r, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_op[3*r +: 3]          = op;
    req_a[32*r +: 32]         = a;
    req_b[32*r +: 32]         = b;
    req_tag[TAG_W*r +: TAG_W] = tag;
  endtask

  // Issues one op, measures edges from accept to res_valid; handshakes only if res_ready is high.
  task automatic run_op(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, output logic [31:0] data,
                        output logic [TAG_W-1:0] rtag, output int lat);
    int w;
    @(negedge clk);
    load_req(r, op, a, b, tag);
    req_valid[r] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[r] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    data = res_data;
    rtag = res_tag;
    if (res_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({res_valid, busy, res_data, res_tag, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b busy=%b data=%h tag=%h ready=%b want all zero",
               res_valid, busy, res_data, res_tag, req_ready);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd2, 3'd1};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    int l;
    for (int i = 0; i < 4; i++) begin
      run_op(0, ops[i], as[i], bs[i], TAG_W'(i + 1), d, t, l);
      checks++;
      if (d !== exp[i]) begin
        errors++; $display("FAIL mul_data[%0d] got %h want %h", i, d, exp[i]);
      end
      checks++;
      if (l !== 3) begin
        errors++; $display("FAIL mul_latency[%0d] got %0d want 3", i, l);
      end
      checks++;
      if (t !== TAG_W'(i + 1)) begin
        errors++; $display("FAIL mul_tag[%0d] got %h want %h", i, t, TAG_W'(i + 1));
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd20, 32'd20};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFA, 32'd2};
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    int l;
    for (int i = 0; i < 6; i++) begin
      run_op(1, ops[i], as[i], bs[i], 5'd10, d, t, l);
      checks++;
      if (d !== exp[i]) begin
        errors++; $display("FAIL div_data[%0d] got %h want %h", i, d, exp[i]);
      end
      checks++;
      if (l !== 33) begin
        errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, l);
      end
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  ops [5] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd6};
    logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0};
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    int l;
    for (int i = 0; i < 5; i++) begin
      run_op(0, ops[i], as[i], bs[i], 5'd4, d, t, l);
      checks++;
      if (d !== exp[i]) begin
        errors++; $display("FAIL divspec_data[%0d] got %h want %h", i, d, exp[i]);
      end
      checks++;
      if (l !== 1) begin
        errors++; $display("FAIL divspec_latency[%0d] got %0d want 1", i, l);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] expg;
    int w;
    do_reset();
    load_req(0, 3'd0, 32'd3, 32'd5, 5'd3);
    load_req(1, 3'd0, 32'd6, 32'd7, 5'd9);
    req_valid = 2'b11;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        @(negedge clk); req_valid = 2'b10;
      end
      expg = (i < 4 && (i % 2) == 0) ? 2'b01 : 2'b10;
      w = 0;
      #1;
      while (req_ready === 2'b00 && w < 20) begin
        @(negedge clk); #1; w++;
      end
      checks++;
      if (req_ready !== expg) begin
        errors++; $display("FAIL rr_grant[%0d] got %b want %b", i, req_ready, expg);
      end
      @(posedge clk); #1;
      w = 0;
      while (!res_valid && w < 20) begin
        @(posedge clk); #1; w++;
      end
      checks++;
      if (res_tag !== (expg[1] ? 5'd9 : 5'd3)) begin
        errors++; $display("FAIL rr_tag[%0d] got %h want %h", i, res_tag, expg[1] ? 5'd9 : 5'd3);
      end
      checks++;
      if (res_data !== (expg[1] ? 32'd42 : 32'd15)) begin
        errors++; $display("FAIL rr_data[%0d] got %h want %h", i, res_data, expg[1] ? 32'd42 : 32'd15);
      end
      @(posedge clk); #1;
      if (i == 6) req_valid = 2'b00;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    int l;
    @(negedge clk); res_ready = 1'b0;
    run_op(0, 3'd0, 32'd9, 32'd9, 5'd5, d, t, l);
    load_req(1, 3'd0, 32'd2, 32'd2, 5'd6);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({res_valid, res_data, res_tag, req_ready, busy} !== {1'b1, 32'd81, 5'd5, 2'b00, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valid=%b data=%h tag=%h ready=%b busy=%b want 1/00000051/05/00/1",
                 i, res_valid, res_data, res_tag, req_ready, busy);
      end
    end
    @(negedge clk); res_ready = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if ({busy, res_valid} !== 2'b00) begin
      errors++; $display("FAIL stall_release got busy=%b valid=%b want 0/0", busy, res_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    int l;
    logic seen;
    int w;
    @(negedge clk);
    load_req(0, 3'd5, 32'd100, 32'd7, 5'd2);
    req_valid[0] = 1'b1;
    #1; w = 0;
    while (!req_ready[0] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checks++;
    if ({busy, res_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_idle got busy=%b valid=%b want 0/0", busy, res_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1; if (res_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_discard got res_valid seen=%b want 0", seen);
    end
    @(negedge clk);
    load_req(1, 3'd0, 32'd4, 32'd4, 5'd8);
    req_valid[1] = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL flush_ready got %b want 00", req_ready);
    end
    @(posedge clk); #1 flush = 1'b0; req_valid = '0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_no_accept got busy=%b want 0", busy);
    end
    run_op(1, 3'd0, 32'd11, 32'd3, 5'd12, d, t, l);
    checks++;
    if ({d, t, l} !== {32'd33, 5'd12, 32'd3}) begin
      errors++; $display("FAIL post_flush got data=%h tag=%h lat=%0d want 00000021/0c/3", d, t, l);
    end
  endtask

  task automatic test_reset_mid_mul();
    int w;
    @(negedge clk);
    load_req(0, 3'd0, 32'd5, 32'd5, 5'd7);
    req_valid[0] = 1'b1;
    #1; w = 0;
    while (!req_ready[0] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_mul_busy got %b want 1", busy);
    end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if ({res_valid, busy, res_data, res_tag, req_ready} !== '0) begin
      errors++;
      $display("FAIL rst_mid_mul got valid=%b busy=%b data=%h tag=%h ready=%b want all zero",
               res_valid, busy, res_data, res_tag, req_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({res_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_abort got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
